// File: rtl/load_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : load_hazard_ctrl
//  Purpose  : Carries the load destination down E/M/W, detects load-use and
//             memory-wait hazards, and drives the stall/bubble controls.
//             Optional HAZARD_STAT_EN adds saturating hazard counters.
//  Revision : 1.0  initial release
// ============================================================================
module load_hazard_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_dstM,
  input  logic [4:0]       d_srcA,
  input  logic [4:0]       d_srcB,
  input  logic             d_valid,
  input  logic             m_ready,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_bubble,
  output logic             M_stall,
  output logic [4:0]       E_dstM,
  output logic [4:0]       M_dstM,
  output logic [4:0]       W_dstM,
  output logic             W_loadwe,
  output logic             mem_timeout
`ifdef HAZARD_STAT_EN
  ,
  output logic [CNT_W-1:0] lu_count,
  output logic [CNT_W-1:0] mw_count
`endif
);

  // One spare count value so the increment never wraps at the limit.
  localparam int                  c_WAIT_W = $clog2(WAIT_LIMIT + 2);
  localparam logic [c_WAIT_W-1:0] c_LIMIT  = c_WAIT_W'(WAIT_LIMIT);
  localparam logic [c_WAIT_W-1:0] c_ONE    = c_WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [4:0]          r_e_dstm;
  logic [4:0]          r_m_dstm;
  logic [4:0]          r_w_dstm;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_inc;
  logic                r_timeout;
  logic                w_lu;
  logic                w_mw;

  always_comb begin
    w_lu         = 1'b0;
    w_mw         = 1'b0;
    w_next_state = ST_RUN;
    F_stall      = 1'b0;
    D_stall      = 1'b0;
    E_bubble     = 1'b0;
    M_stall      = 1'b0;

    // Register 0 is excluded by requiring a non-zero load destination.
    w_lu = d_valid && (r_e_dstm != 5'd0) &&
           ((r_e_dstm == d_srcA) || (r_e_dstm == d_srcB));
    w_mw = (r_m_dstm != 5'd0) && !m_ready;

    if (!reset) begin
      if (w_mw) begin
        w_next_state = ST_MEM_WAIT;
        F_stall      = 1'b1;
        D_stall      = 1'b1;
        M_stall      = 1'b1;
      end else if (w_lu) begin
        w_next_state = ST_LU_STALL;
        F_stall      = 1'b1;
        D_stall      = 1'b1;
        E_bubble     = 1'b1;
      end
    end
  end

  assign w_wait_inc = r_wait_cnt + c_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_e_dstm   <= 5'd0;
      r_m_dstm   <= 5'd0;
      r_w_dstm   <= 5'd0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_mw) begin
        // E and M hold; W takes a bubble so the load is not written twice.
        r_w_dstm <= 5'd0;
        if (r_wait_cnt != c_LIMIT) begin
          r_wait_cnt <= w_wait_inc;
        end
        if (w_wait_inc >= c_LIMIT) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_w_dstm <= r_m_dstm;
        r_m_dstm <= r_e_dstm;
        r_e_dstm <= (w_lu || !d_valid) ? 5'd0 : d_dstM;
        if (r_state == ST_MEM_WAIT) begin
          r_wait_cnt <= '0;
        end
      end
    end
  end

  assign E_dstM      = r_e_dstm;
  assign M_dstM      = r_m_dstm;
  assign W_dstM      = r_w_dstm;
  assign W_loadwe    = (r_w_dstm != 5'd0);
  assign mem_timeout = r_timeout;

`ifdef HAZARD_STAT_EN
  logic [CNT_W-1:0] r_lu_count;
  logic [CNT_W-1:0] r_mw_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lu_count <= '0;
      r_mw_count <= '0;
    end else begin
      if (E_bubble && (r_lu_count != '1)) begin
        r_lu_count <= r_lu_count + CNT_W'(1);
      end
      if (M_stall && (r_mw_count != '1)) begin
        r_mw_count <= r_mw_count + CNT_W'(1);
      end
    end
  end

  assign lu_count = r_lu_count;
  assign mw_count = r_mw_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_hazard_ctrl
//  Purpose  : Scoreboard bench for load_hazard_ctrl; directed scenarios then
//             random traffic against a behavioural pipeline model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_hazard_ctrl;

  localparam int WAIT_LIMIT = 15;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       d_dstM, d_srcA, d_srcB;
  logic             d_valid, m_ready;
  logic             F_stall, D_stall, E_bubble, M_stall;
  logic [4:0]       E_dstM, M_dstM, W_dstM;
  logic             W_loadwe, mem_timeout;
  logic [CNT_W-1:0] lu_count, mw_count;

  load_hazard_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_valid(d_valid), .m_ready(m_ready),
    .F_stall(F_stall), .D_stall(D_stall), .E_bubble(E_bubble), .M_stall(M_stall),
    .E_dstM(E_dstM), .M_dstM(M_dstM), .W_dstM(W_dstM),
    .W_loadwe(W_loadwe), .mem_timeout(mem_timeout)
`ifdef HAZARD_STAT_EN
    , .lu_count(lu_count), .mw_count(mw_count)
`endif
  );

`ifndef HAZARD_STAT_EN
  assign lu_count = '0;
  assign mw_count = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       ctrl;
    logic [15:0]      dst;
    logic             to;
    logic [CNT_W-1:0] luc;
    logic [CNT_W-1:0] mwc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   chk_en = 0;

  // Behavioural model: a 3-deep destination pipe [E, M, W] plus wait tracking.
  int   m_pipe[3];
  int   m_wait;
  bit   m_to;
  int   m_luc, m_mwc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("ctrl", {28'd0, F_stall, D_stall, E_bubble, M_stall}, {28'd0, e.ctrl});
      chk("dst", {16'd0, E_dstM, M_dstM, W_dstM, W_loadwe}, {16'd0, e.dst});
      chk("timeout", {31'd0, mem_timeout}, {31'd0, e.to});
`ifdef HAZARD_STAT_EN
      chk("lu_count", 32'(lu_count), 32'(e.luc));
      chk("mw_count", 32'(mw_count), 32'(e.mwc));
`endif
    end
  end

  task automatic step(input bit rst, input bit dv, input int dst, input int sa,
                      input int sb, input bit mr);
    exp_t e;
    bit   lu, mw;
    int   nxt[3];
    reset   = rst;
    d_valid = dv;
    d_dstM  = 5'(dst);
    d_srcA  = 5'(sa);
    d_srcB  = 5'(sb);
    m_ready = mr;
    lu = dv && (m_pipe[0] != 0) && (m_pipe[0] == sa || m_pipe[0] == sb);
    mw = (m_pipe[1] != 0) && !mr;
    e.ctrl = 4'b0000;
    if (!rst && mw)      e.ctrl = 4'b1101;
    else if (!rst && lu) e.ctrl = 4'b1110;
    e.dst = {5'(m_pipe[0]), 5'(m_pipe[1]), 5'(m_pipe[2]), m_pipe[2] != 0};
    e.to  = m_to;
    e.luc = CNT_W'(m_luc);
    e.mwc = CNT_W'(m_mwc);
    if (chk_en) sb_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_pipe = '{0, 0, 0};
      m_wait = 0; m_to = 0; m_luc = 0; m_mwc = 0;
    end else if (mw) begin
      m_pipe[2] = 0;
      m_wait++;
      if (m_wait >= WAIT_LIMIT) m_to = 1;
      m_mwc++;
    end else begin
      nxt[0] = (lu || !dv) ? 0 : dst;
      nxt[1] = m_pipe[0];
      nxt[2] = m_pipe[1];
      m_pipe = nxt;
      m_wait = 0;
      if (lu) m_luc++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    m_pipe = '{0, 0, 0};
    m_wait = 0; m_to = 0; m_luc = 0; m_mwc = 0;
    step(1, 0, 0, 0, 0, 1);
    chk_en = 1;
    step(1, 0, 0, 0, 0, 1);
    idle(5);
    // load r8 then a consumer of r8: one bubble, consumer retried
    step(0, 1, 8, 1, 2, 1);
    step(0, 1, 0, 8, 0, 1);
    step(0, 1, 0, 8, 0, 1);
    idle(4);
    // loads to r0 and non-matching sources never stall
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 5, 0, 0, 1);
    step(0, 1, 0, 6, 7, 1);
    idle(4);
    // load r3 waits four cycles in M
    step(0, 1, 3, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    idle(4);
    // memory wait and load-use together; load-use resolves after the wait
    step(0, 1, 3, 0, 0, 1);
    step(0, 1, 9, 0, 0, 1);
    step(0, 1, 0, 9, 0, 0);
    step(0, 1, 0, 9, 0, 0);
    step(0, 1, 0, 9, 0, 1);
    step(0, 1, 0, 9, 0, 1);
    idle(4);
    // timeout is sticky until reset
    step(0, 1, 4, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < WAIT_LIMIT + 2; i++) step(0, 0, 0, 0, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 0, 1);
    idle(2);
    // random traffic, including occasional mid-stall reset
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 3) != 0);
    end
    idle(1);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_hazard_ctrl.md
Name: load_hazard_ctrl

Overview:
- Consumer end of the decode-stage load-destination signal (d_dstM, the load's rt, or 0 when the instruction is not a load).
- Carries d_dstM down the E/M/W pipeline registers.
- Detects load-use hazards against the decode-stage source registers and generates the stall/bubble controls.
- Freezes the pipe while a load in M waits on a slow data memory.
- Sits beside the pipeline registers in the CPU top level.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive memory-wait cycles before mem_timeout is raised.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- d_dstM  input  5  load destination from the decode stage; 0 = none
- d_srcA  input  5  decode-stage source register A (rs)
- d_srcB  input  5  decode-stage source register B (rt)
- d_valid  input  1  decode stage holds a real instruction
- m_ready  input  1  data memory has completed the access in M
- F_stall  output  1  hold PC
- D_stall  output  1  hold the D pipeline register
- E_bubble  output  1  inject a NOP into E
- M_stall  output  1  hold the E and M pipeline registers
- E_dstM  output  5  load destination currently in E
- M_dstM  output  5  load destination currently in M
- W_dstM  output  5  load destination in W; register-file write address for load data
- W_loadwe  output  1  W_dstM != 0
- mem_timeout  output  1  sticky error flag

Behaviour:
- Reset (synchronous, active-high): E_dstM, M_dstM, W_dstM = 0; state = RUN; mem_timeout = 0; wait counter = 0. All control outputs are 0 during and after reset.
- Register 0 is never a hazard source. d_srcA/d_srcB = 0 never match, and d_dstM = 0 means no load.
- Combinational hazard terms:
  - lu = d_valid & (E_dstM != 0) & (E_dstM == d_srcA | E_dstM == d_srcB)
  - mw = (M_dstM != 0) & !m_ready
- Priority: mw over lu.
- State RUN (no hazard): shift the pipeline each cycle.
  - W_dstM <= M_dstM
  - M_dstM <= E_dstM
  - E_dstM <= d_valid ? d_dstM : 0
- RUN with lu and !mw:
  - Outputs: F_stall = D_stall = E_bubble = 1.
  - Next: E_dstM <= 0; M and W shift normally. Go to LU_STALL.
- LU_STALL: exactly one cycle. Controls are recomputed from the current inputs, so a second dependent load re-stalls correctly. Returns to RUN unless lu or mw holds again.
- Any state with mw, entering MEM_WAIT:
  - Outputs: F_stall = D_stall = M_stall = 1; E_bubble = 0.
  - Next: E_dstM and M_dstM hold; W_dstM <= 0, so W gets a bubble and there is no double write.
  - The wait counter increments each cycle in MEM_WAIT.
- MEM_WAIT exit: when m_ready = 1, the shift resumes that cycle and the wait counter clears. lu is evaluated in the same cycle, and the next state is LU_STALL if lu holds.
- Timeout: when the wait counter reaches WAIT_LIMIT, mem_timeout <= 1. It is sticky until reset. The pipe keeps waiting; it does not abort.
- Latency: load-use penalty is exactly 1 cycle. A load's dstM appears on W_dstM 3 cycles after it is accepted in D, plus any wait cycles.
- Reset mid-stall: reset wins in every state; all registers clear the same cycle.
- The outputs stall/bubble/M_stall are combinational from current state and inputs. The dstM registers are the only pipeline state.

Optional Feature:
- Macro: HAZARD_STAT_EN.
- When defined, two extra output ports are added:
  - lu_count [CNT_W-1:0]: increments on every cycle with E_bubble = 1.
  - mw_count [CNT_W-1:0]: increments on every cycle with M_stall = 1.
  - Both saturate at all-ones and clear on reset.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset then idle (d_valid = 0, m_ready = 1, 5 cycles) -> all dstM outputs 0 and all controls 0.
- Load-use: cycle 0 d_dstM = 8, d_valid = 1; cycle 1 d_srcA = 8 -> cycle 1: F_stall = D_stall = E_bubble = 1; cycle 2: E_dstM = 0, M_dstM = 8, no stall; W_dstM = 8 and W_loadwe = 1 one cycle later.
- No false hazard: load to rt = 0, then d_srcB = 0 -> no stall. Load rt = 5 followed by an instruction with srcA = 6, srcB = 7 -> no stall.
- Memory wait: M_dstM = 3 with m_ready low for 4 cycles -> M_stall = 1 for 4 cycles, E/M held, W_dstM = 0 throughout; m_ready high -> W_dstM = 3 next cycle.
- Simultaneous: mw and lu in the same cycle -> M_stall = 1, E_bubble = 0. After m_ready rises, one LU_STALL cycle follows with E_bubble = 1.
- Timeout: m_ready held low for WAIT_LIMIT + 2 cycles -> mem_timeout rises after WAIT_LIMIT cycles and stays 1 after m_ready returns, until reset. With HAZARD_STAT_EN defined, mw_count equals the number of wait cycles.
